// File: rtl/mem_port_arbiter.sv
// Single-port arbiter in front of the unified instruction/data memory: picks a
// fetch or load/store request, drives the memory port for one cycle and captures Rd.
module mem_port_arbiter #(
  parameter int          DEPTH     = 64,
  parameter int          AW        = 6,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        IfReq,
  input  logic [31:0] IfAddr,
  output logic        IfAck,
  output logic [31:0] Instr,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWd,
  output logic        DAck,
  output logic [31:0] DRd,
  output logic        Err,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWd,
  input  logic [31:0] MemRd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  // A byte address is unusable if it is not word aligned or lies beyond DEPTH words.
  function automatic logic addr_bad(input logic [31:0] addr);
    addr_bad = (addr[1:0] != 2'b00) || (addr[31:AW+2] != {(30-AW){1'b0}});
  endfunction

  state_t      state_r;
  logic        if_ack_r;
  logic        d_ack_r;
  logic        err_r;
  logic        lat_bad_r;
  logic        mem_we_r;
  logic [31:0] instr_r;
  logic [31:0] drd_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wd_r;

  logic        take_d_s;
  logic        take_if_s;
  logic [31:0] sel_addr_s;
  logic        sel_bad_s;

  // Request selection: nothing is accepted while an Ack is showing, data wins over fetch.
  always_comb begin
    take_d_s  = 1'b0;
    take_if_s = 1'b0;
    if ((state_r == IDLE) && !if_ack_r && !d_ack_r) begin
      if (DReq) begin
        take_d_s = 1'b1;
      end else if (IfReq) begin
        take_if_s = 1'b1;
      end else begin
        take_d_s  = 1'b0;
        take_if_s = 1'b0;
      end
    end else begin
      take_d_s  = 1'b0;
      take_if_s = 1'b0;
    end
  end

  // Address of whichever request is being accepted this cycle.
  always_comb begin
    if (take_d_s) begin
      sel_addr_s = DAddr;
    end else begin
      sel_addr_s = IfAddr;
    end
    sel_bad_s = addr_bad(sel_addr_s);
  end

  // Arbiter FSM with all port-facing outputs registered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= IDLE;
      if_ack_r   <= 1'b0;
      d_ack_r    <= 1'b0;
      err_r      <= 1'b0;
      lat_bad_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      instr_r    <= NOP_INSTR;
      drd_r      <= 32'h0000_0000;
      mem_addr_r <= 32'h0000_0000;
      mem_wd_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if_ack_r <= 1'b0;
          d_ack_r  <= 1'b0;
          err_r    <= 1'b0;
          if (take_d_s) begin
            mem_addr_r <= {{(32-AW){1'b0}}, sel_addr_s[AW+1:2]};
            mem_wd_r   <= DWd;
            lat_bad_r  <= sel_bad_s;
            // Write enable is armed here so it is clean for the whole STORE cycle.
            mem_we_r   <= DWe & ~sel_bad_s;
            state_r    <= DWe ? STORE : LOAD;
          end else if (take_if_s) begin
            mem_addr_r <= {{(32-AW){1'b0}}, sel_addr_s[AW+1:2]};
            lat_bad_r  <= sel_bad_s;
            mem_we_r   <= 1'b0;
            state_r    <= FETCH;
          end else begin
            mem_we_r   <= 1'b0;
            state_r    <= IDLE;
          end
        end
        FETCH: begin
          if (!lat_bad_r) begin
            instr_r <= MemRd;
          end else begin
            instr_r <= instr_r;
          end
          if_ack_r <= 1'b1;
          err_r    <= lat_bad_r;
          mem_we_r <= 1'b0;
          state_r  <= IDLE;
        end
        LOAD: begin
          if (!lat_bad_r) begin
            drd_r <= MemRd;
          end else begin
            drd_r <= drd_r;
          end
          d_ack_r  <= 1'b1;
          err_r    <= lat_bad_r;
          mem_we_r <= 1'b0;
          state_r  <= IDLE;
        end
        STORE: begin
          d_ack_r  <= 1'b1;
          err_r    <= lat_bad_r;
          mem_we_r <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          if_ack_r <= 1'b0;
          d_ack_r  <= 1'b0;
          err_r    <= 1'b0;
          mem_we_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign IfAck   = if_ack_r;
  assign DAck    = d_ack_r;
  assign Err     = err_r;
  assign Instr   = instr_r;
  assign DRd     = drd_r;
  assign MemWe   = mem_we_r;
  assign MemAddr = mem_addr_r;
  assign MemWd   = mem_wd_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 64x32 combinational-read memory model.
module tb_mem_port_arbiter;

  logic        Clk;
  logic        Rst_n;
  logic        IfReq;
  logic [31:0] IfAddr;
  logic        IfAck;
  logic [31:0] Instr;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWd;
  logic        DAck;
  logic [31:0] DRd;
  logic        Err;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWd;
  logic [31:0] MemRd;

  logic [31:0] mem [64];
  logic        mem_init;

  int n_pass;
  int n_total;

  mem_port_arbiter #(.DEPTH(64), .AW(6), .NOP_INSTR(32'h0000_0000)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfAck(IfAck), .Instr(Instr),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWd(DWd), .DAck(DAck), .DRd(DRd),
    .Err(Err), .MemWe(MemWe), .MemAddr(MemAddr), .MemWd(MemWd), .MemRd(MemRd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: word i starts as 0x1000_0000+i, synchronous write, async read.
  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (MemWe) begin
      mem[MemAddr[5:0]] <= MemWd;
    end
  end
  assign MemRd = mem[MemAddr[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge Clk);
    if (v.is_d) begin
      DReq = 1'b1; DWe = v.we; DAddr = v.addr; DWd = v.wd;
    end else begin
      IfReq = 1'b1; IfAddr = v.addr;
    end
    @(posedge Clk); #1;
    chk({tag, "_memaddr"}, MemAddr, v.exp_addr);
    chk({tag, "_memwe"}, {31'd0, MemWe}, {31'd0, v.exp_we});
    @(posedge Clk); #1;
    chk({tag, "_ack"}, {31'd0, v.is_d ? DAck : IfAck}, 32'd1);
    chk({tag, "_other_ack"}, {31'd0, v.is_d ? IfAck : DAck}, 32'd0);
    chk({tag, "_err"}, {31'd0, Err}, {31'd0, v.exp_err});
    chk({tag, "_data"}, v.is_d ? DRd : Instr, v.exp_rd);
    chk({tag, "_we_off"}, {31'd0, MemWe}, 32'd0);
    IfReq = 1'b0; DReq = 1'b0;
    @(posedge Clk); #1;
    chk({tag, "_ack_pulse"}, {30'd0, IfAck, DAck}, 32'd0);
  endtask

  initial begin
    int d_cyc, i_cyc, k;
    int ack_cyc[3];
    logic instr_held;

    n_pass = 0; n_total = 0;
    Rst_n = 1'b0; mem_init = 1'b1;
    IfReq = 1'b0; IfAddr = 32'h0; DReq = 1'b0; DWe = 1'b0; DAddr = 32'h0; DWd = 32'h0;

    //            is_d  we    addr          wd            exp_addr  we    err   exp_rd
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,        32'd2,  1'b0, 1'b0, 32'h1000_0002};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'd4,  1'b1, 1'b0, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'd4,  1'b0, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0012, 32'hCAFEF00D, 32'd4,  1'b0, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'd4,  1'b0, 1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'd0,  1'b0, 1'b1, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,        32'd0,  1'b0, 1'b1, 32'h1000_0002};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0,        32'd63, 1'b0, 1'b0, 32'h1000_003F};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_00FC, 32'h12345678, 32'd63, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,        32'd63, 1'b0, 1'b0, 32'h12345678};

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_instr", Instr, 32'h0000_0000);
    chk("rst_drd", DRd, 32'h0);
    chk("rst_flags", {28'd0, IfAck, DAck, Err, MemWe}, 32'h0);
    chk("rst_memaddr", MemAddr, 32'h0);
    chk("rst_memwd", MemWd, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1; mem_init = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Simultaneous data and fetch requests.
    d_cyc = -1; i_cyc = -1; instr_held = 1'b1;
    @(negedge Clk);
    IfReq = 1'b1; IfAddr = 32'h4; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h10;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clk); #1;
      if (DAck && d_cyc < 0) begin
        d_cyc = c; DReq = 1'b0;
        chk("both_drd", DRd, 32'hDEADBEEF);
      end
      if (IfAck && i_cyc < 0) begin
        i_cyc = c; IfReq = 1'b0;
        chk("both_instr", Instr, 32'h1000_0001);
      end else if (i_cyc < 0 && Instr !== 32'h1000_003F) begin
        instr_held = 1'b0;
      end
    end
    chk("both_dack_cycle", 32'(d_cyc), 32'd1);
    chk("both_gap", 32'(i_cyc - d_cyc), 32'd3);
    chk("both_instr_held", {31'd0, instr_held}, 32'd1);

    // Back-to-back fetches with IfReq held.
    k = 0;
    @(negedge Clk);
    IfReq = 1'b1; IfAddr = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk); #1;
      if (IfAck) begin
        if (k < 3) begin
          ack_cyc[k] = c;
          chk($sformatf("b2b_instr%0d", k), Instr, 32'h1000_0000 + 32'(k));
        end
        k++;
        if (k >= 3) IfReq = 1'b0;
        else IfAddr = 32'(4 * k);
      end
    end
    chk("b2b_count", 32'(k), 32'd3);
    chk("b2b_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    chk("b2b_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);

    // Reset in the middle of a STORE cycle.
    @(negedge Clk);
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h20; DWd = 32'h55AA55AA;
    @(posedge Clk); #1;
    chk("rst_mid_we_before", {31'd0, MemWe}, 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("rst_mid_we", {31'd0, MemWe}, 32'd0);
    chk("rst_mid_flags", {29'd0, IfAck, DAck, Err}, 32'd0);
    chk("rst_mid_instr", Instr, 32'h0);
    chk("rst_mid_drd", DRd, 32'h0);
    chk("rst_mid_addr", MemAddr, 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    DReq = 1'b0; Rst_n = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
      chk("rst_mid_no_dack", {31'd0, DAck}, 32'd0);
    end
    chk("rst_mid_word", mem[8], 32'h1000_0008);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
